// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown controller.
package countdown_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned CNT_W      = 3;
  localparam logic [2:0]  RELOAD_SAT = 3'd7;

endpackage

// File: rtl/countdown_ctrl_decrement.sv
// 3-bit combinational decrementer, Y = A - 1 modulo 8.
module decrement (
  input  logic [2:0] a,
  output logic [2:0] y
);

  assign y = a - 3'd1;

endmodule

// File: rtl/countdown_ctrl.sv
// Loadable, prescaled countdown timer built around the decrement unit,
// with start/ready handshake, pause, abort and optional auto-reload.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic [2:0]       reloads
);

  localparam int unsigned PRE_W = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_val_q, reload_val_d;
  logic             ar_q, ar_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       reloads_q, reloads_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] dec_y;

  decrement u_decrement (
    .a (count_q),
    .y (dec_y)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reload_val_d = reload_val_q;
    ar_d         = ar_q;
    pre_d        = pre_q;
    reloads_d    = reloads_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d      = load_val;
          reload_val_d = load_val;
          ar_d         = auto_reload;
          pre_d        = '0;
          reloads_d    = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (!pause) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            // Counts of 0 and 1 both expire, so the decrementer never wraps.
            if (count_q <= CNT_W'(1)) begin
              done_d = 1'b1;
              if (ar_q) begin
                count_d   = reload_val_q;
                reloads_d = (reloads_q == RELOAD_SAT) ? RELOAD_SAT : reloads_q + 3'd1;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = dec_y;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      reload_val_q <= '0;
      ar_q         <= 1'b0;
      pre_q        <= '0;
      reloads_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_val_q <= reload_val_d;
      ar_q         <= ar_d;
      pre_q        <= pre_d;
      reloads_q    <= reloads_d;
      done_q       <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign count   = count_q;
  assign done    = done_q;
  assign reloads = reloads_q;

endmodule
